// File: rtl/sram_pkg.sv
// Shared encodings and payload types for the sram32 load/store front end.
package sram_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBYTES = XLEN / 8;
    localparam int unsigned OFF_W  = 2;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    // Request attributes carried alongside the single outstanding response.
    typedef struct packed {
        logic             we;
        size_e            size;
        logic             sgn;
        logic [OFF_W-1:0] off;
        logic             err;
    } rsp_meta_t;

endpackage

// File: rtl/dffl.sv
// Enabled flop primitive with asynchronous active-low clear.
module dffl #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/lsu_load_fmt.sv
// Load lane select and sign/zero extension; shared with the core writeback path.
module lsu_load_fmt
    import sram_pkg::*;
(
    input  size_e            size_i,
    input  logic             sgn_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [XLEN-1:0]  dout_i,
    output logic [XLEN-1:0]  data_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Halves only ever start on lane 0 or 2, so off_i[0] is irrelevant for them.
    assign byte_c = dout_i[{off_i, 3'b000} +: 8];
    assign half_c = dout_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = dout_i;
        case (size_i)
            SZ_B:    data_o = {{24{sgn_i & byte_c[7]}}, byte_c};
            SZ_H:    data_o = {{16{sgn_i & half_c[15]}}, half_c};
            default: data_o = dout_i;
        endcase
    end

endmodule

// File: rtl/sram32_lsu_port.sv
// LSU request/response front end for the byte-enabled sram32 word SRAM.
module sram32_lsu_port
    import sram_pkg::*;
#(
    parameter int unsigned ADR_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [XLEN-1:0]   req_adr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              sram_en,
    output logic [NBYTES-1:0] sram_we,
    output logic [XLEN-1:0]   sram_adr,
    input  logic [XLEN-1:0]   sram_dout,
    output logic [XLEN-1:0]   sram_din
);

    size_e             size_c;
    logic              err_c;
    logic              accept_c;
    logic [NBYTES-1:0] be_c;
    logic              rsp_valid_d, rsp_valid_q;
    logic              fresh_q;
    logic              hold_en_c;
    logic [XLEN-1:0]   hold_q;
    logic [XLEN-1:0]   fmt_c;
    rsp_meta_t         meta_d, meta_q;

    assign size_c    = size_e'(req_size);
    assign req_ready = !rsp_valid_q | rsp_ready;
    assign accept_c  = req_valid & req_ready;

    // Alignment, reserved size and address window check.
    always_comb begin
        err_c = 1'b0;
        case (size_c)
            SZ_H:    err_c = req_adr[0];
            SZ_W:    err_c = |req_adr[1:0];
            SZ_RSV:  err_c = 1'b1;
            default: err_c = 1'b0;
        endcase
        if ((req_adr >> ADR_BITS) != '0) begin
            err_c = 1'b1;
        end
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        be_c     = 4'b1111;
        sram_din = req_wdata;
        case (size_c)
            SZ_B: begin
                be_c     = 4'(4'b0001 << req_adr[1:0]);
                sram_din = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                be_c     = req_adr[1] ? 4'b1100 : 4'b0011;
                sram_din = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c     = 4'b1111;
                sram_din = req_wdata;
            end
        endcase
    end

    assign sram_en  = accept_c & !err_c;
    assign sram_we  = (sram_en & req_we) ? be_c : '0;
    assign sram_adr = req_adr;

    assign rsp_valid_d = accept_c | (rsp_valid_q & !rsp_ready);

    always_comb begin
        meta_d      = '0;
        meta_d.we   = req_we;
        meta_d.size = size_c;
        meta_d.sgn  = req_signed;
        meta_d.off  = req_adr[1:0];
        meta_d.err  = err_c;
    end

    dffl #(.W(1)) u_valid (
        .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(rsp_valid_d), .q_o(rsp_valid_q)
    );

    // fresh marks the first response cycle, when sram_dout still holds our read.
    dffl #(.W(1)) u_fresh (
        .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(accept_c), .q_o(fresh_q)
    );

    dffl #(.W($bits(rsp_meta_t))) u_meta (
        .clk(clk), .rst_n(rst_n), .en_i(accept_c), .d_i(meta_d), .q_o(meta_q)
    );

    lsu_load_fmt u_fmt (
        .size_i(meta_q.size),
        .sgn_i (meta_q.sgn),
        .off_i (meta_q.off),
        .dout_i(sram_dout),
        .data_o(fmt_c)
    );

    // Capture load data before the SRAM address register moves on.
    assign hold_en_c = rsp_valid_q & fresh_q & !rsp_ready;

    dffl #(.W(XLEN)) u_hold (
        .clk(clk), .rst_n(rst_n), .en_i(hold_en_c), .d_i(fmt_c), .q_o(hold_q)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q & meta_q.err;
    assign rsp_rdata = (!rsp_valid_q | meta_q.we | meta_q.err) ? '0
                     : (fresh_q ? fmt_c : hold_q);

endmodule

// File: tb/tb_sram32_lsu_port.sv
// Scoreboard bench for sram32_lsu_port with a byte-array reference memory and an sram32 model.
module tb_sram32_lsu_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_adr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_adr, sram_dout, sram_din;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    logic [7:0]  mem_m    [0:65535];
    logic [31:0] sram_mem [0:16383];
    logic [13:0] sram_adr_q;

    bit bp_force = 1'b1;
    bit bp_val   = 1'b1;

    sram32_lsu_port #(.ADR_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_adr(req_adr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .sram_en(sram_en),
        .sram_we(sram_we), .sram_adr(sram_adr), .sram_dout(sram_dout),
        .sram_din(sram_din)
    );

    initial forever #5 clk = ~clk;

    // sram32: byte-enabled write, address register loaded every cycle.
    always @(posedge clk) begin
        if (sram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_we[b]) sram_mem[sram_adr[15:2]][b*8 +: 8] <= sram_din[b*8 +: 8];
            end
        end
        sram_adr_q <= sram_adr[15:2];
    end
    assign sram_dout = sram_mem[sram_adr_q];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || (a > 32'h0000_FFFF);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        int unsigned base;
        logic [15:0] h;
        logic [31:0] r;
        base = a & 32'h0000_FFFF;
        case (sz)
            2'd0: r = {{24{sg & mem_m[base][7]}}, mem_m[base]};
            2'd1: begin
                h = {mem_m[base+1], mem_m[base]};
                r = {{16{sg & h[15]}}, h};
            end
            default: begin
                base = base & ~32'h3;
                r = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
            end
        endcase
        return r;
    endfunction

    // Response backpressure: directed value or random.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = bp_force ? bp_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare every visible response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready_rule", 32'(req_ready), 32'(!rsp_valid || rsp_ready));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %h with empty scoreboard at %0t", rsp_rdata, $time);
                end else begin
                    chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                    chk("rsp_rdata", rsp_rdata, sb[0].rdata);
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // Drives a request, leaving it on the bus until the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        logic        done;
        logic        e;
        logic [3:0]  be;
        logic [31:0] din;
        exp_t        x;
        done = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_adr = a; req_wdata = wd;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1;
                e = ref_err(sz, a);
                chk("sram_en", 32'(sram_en), 32'(!e));
                chk("sram_adr", sram_adr, a);
                be = 4'b0000;
                if (we && !e) begin
                    case (sz)
                        2'd0:    be = 4'(4'd1 << a[1:0]);
                        2'd1:    be = 4'(4'd3 << a[1:0]);
                        default: be = 4'hF;
                    endcase
                end
                chk("sram_we", 32'(sram_we), 32'(be));
                if (sz != 2'd3) begin
                    din = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
                    chk("sram_din", sram_din, din);
                end
                if (we && !e) begin
                    for (int k = 0; k < (1 << sz); k++) mem_m[(a & 32'hFFFF) + k] = wd[k*8 +: 8];
                end
                x.err   = e;
                x.rdata = (we || e) ? 32'h0 : ref_load(sz, sg, a);
                sb.push_back(x);
            end else begin
                chk("stall_sram_en", 32'(sram_en), 32'h0);
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: request at %h not accepted within 64 cycles", a);
            req_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] w, a;
        logic [1:0]  sz;
        int          r;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_adr = 32'h0; req_wdata = 32'h0; sram_adr_q = '0;
        for (int i = 0; i < 16384; i++) begin
            w = $urandom;
            sram_mem[i] = w;
            for (int b = 0; b < 4; b++) mem_m[i*4 + b] = w[b*8 +: 8];
        end
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;

        // Word round trip and byte/half extension.
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h80FF7F01);
        issue(1'b0, 2'd0, 1'b1, 32'h202, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h203, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h202, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h201, 32'h55);

        // Backpressure while the next load waits on the bus.
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        bp_val = 1'b0;
        fork
            issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
            begin
                repeat (4) @(posedge clk);
                bp_val = 1'b1;
            end
        join

        // Errored requests.
        issue(1'b0, 2'd1, 1'b0, 32'h101, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'hCAFEF00D);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);

        // Store immediately followed by a load of the same word.
        issue(1'b1, 2'd2, 1'b0, 32'h300, 32'h12345678);
        issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);

        // Asynchronous reset while a response is stalled.
        issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        bp_val = 1'b0;
        idle(1);
        for (int t = 0; t < 10 && !rsp_valid; t++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop_rst_valid", 32'(rsp_valid), 32'h0);
        chk("midop_rst_rdata", rsp_rdata, 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bp_val = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);

        // Randomized traffic with random backpressure.
        bp_force = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
            r  = int'($urandom_range(0, 15));
            sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
            a  = 32'($urandom_range(0, 1023));
            if (sz != 2'd3 && $urandom_range(0, 9) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 19) == 0) a = a | (32'd1 << $urandom_range(16, 31));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        bp_force = 1'b1;
        bp_val   = 1'b1;
        idle(1);
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
